param_regfile: RTL

Parameterised multi-read-port register file for the pipelined CPU datapath. It generalises the single-bit enabled flip-flop into WIDTH-bit words with configurable DEPTH and read-port count. It includes a hardwired zero register and an optional same-cycle write-to-read bypass. It sits in the decode stage: the writeback stage drives the write port, and decode reads operands combinationally.

---
 rtl/param_regfile.sv | 88 ++++++++
 1 files changed

// File: rtl/param_regfile.sv
// param_regfile: WIDTH x DEPTH register file with NUM_READ combinational
// read ports, optional hardwired zero register and optional write bypass.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low; clears every register
//   wr_en    in   write enable
//   wr_addr  in   [AW-1:0] write index
//   wr_data  in   [WIDTH-1:0] write word
//   rd_addr  in   [NUM_READ*AW-1:0] packed read indices, port p at [p*AW +: AW]
//   rd_data  out  [NUM_READ*WIDTH-1:0] packed read words, port p at [p*WIDTH +: WIDTH]
//
// Build option: define REGFILE_BYPASS_EN to forward wr_data to any read
// port addressing wr_addr in the same cycle.
module param_regfile #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_IDX = 31,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*WIDTH-1:0] rd_data
);

  // Zero register only exists when its index lands inside the array.
  localparam bit ZERO_EN =
    (ZERO_IDX >= 0) && (ZERO_IDX < DEPTH);

  // Index is backed by real storage: in range and not the zero register.
  function automatic logic idx_ok(input logic [AW-1:0] a);
    idx_ok = (int'(a) < DEPTH) &&
             !(ZERO_EN && (int'(a) == ZERO_IDX));
  endfunction

  logic             wr_ok;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  assign wr_ok = wr_en && idx_ok(wr_addr);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && (int'(wr_addr) == i))
        regs_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= regs_d[i];
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;

    assign ra = rd_addr[p*AW +: AW];

    // AND-OR select: an out-of-range index matches nothing and reads 0.
    always_comb begin
      rv = '0;
      for (int i = 0; i < DEPTH; i++)
        if (int'(ra) == i)
          rv = regs_q[i];
      if (!idx_ok(ra))
        rv = '0;
`ifdef REGFILE_BYPASS_EN
      if (reset && wr_ok && (ra == wr_addr))
        rv = wr_data;
`endif
    end

    assign rd_data[p*WIDTH +: WIDTH] = rv;
  end

endmodule
